// File: rtl/trace_buffer_reader.sv
// Drain side of the NoC flit trace buffer: pops trace words on a dump request and
// serialises them MSB-first as an A5 ... 5A framed valid/ready byte stream.
module trace_buffer_reader #(
    parameter int Fpay     = 32,
    parameter int TB_Depth = 512,
    parameter int CNTw     = 10
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            dump_req,
    input  logic            tb_empty,
    input  logic [Fpay-1:0] fifo_dout,
    output logic            fifo_rd,
    output logic [7:0]      byte_out,
    output logic            byte_valid,
    input  logic            byte_ready,
    output logic            busy,
    output logic [CNTw-1:0] words_sent
);
    localparam int NB = Fpay / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [CNTw-1:0] DEPTH = CNTw'(TB_Depth);
    localparam logic [IW-1:0]   LAST  = IW'(NB - 1);
    localparam logic [7:0]      HDR_B = 8'hA5;
    localparam logic [7:0]      TRL_B = 8'h5A;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_RD, S_LAT, S_SEND, S_TRL} state_t;

    state_t          state_q, state_d;
    logic [Fpay-1:0] word_q, word_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CNTw-1:0] ws_q, ws_d;
    logic [Fpay-1:0] word_sh;
    logic            at_cap;
    logic            xfer;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            idx_q   <= '0;
            ws_q    <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            ws_q    <= ws_d;
        end
    end

    assign at_cap     = (ws_q == DEPTH);
    // Pop only from a non-empty FIFO and only while under the per-dump cap.
    assign fifo_rd    = (state_q == S_RD) && !tb_empty && !at_cap;
    assign byte_valid = (state_q == S_HDR) || (state_q == S_SEND) || (state_q == S_TRL);
    assign xfer       = byte_valid && byte_ready;
    assign busy       = (state_q != S_IDLE);
    assign words_sent = ws_q;
    assign word_sh    = word_q << {idx_q, 3'b000};

    always_comb begin
        byte_out = 8'h00;
        case (state_q)
            S_HDR:   byte_out = HDR_B;
            S_SEND:  byte_out = word_sh[Fpay-1 -: 8];
            S_TRL:   byte_out = TRL_B;
            default: byte_out = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        ws_d    = ws_q;
        case (state_q)
            S_IDLE: if (dump_req) begin
                state_d = S_HDR;
                ws_d    = '0;
            end
            S_HDR:  if (xfer) state_d = S_RD;
            S_RD:   state_d = fifo_rd ? S_LAT : S_TRL;
            S_LAT: begin
                word_d  = fifo_dout;
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: if (xfer) begin
                if (idx_q == LAST) begin
                    ws_d    = at_cap ? ws_q : ws_q + 1'b1;
                    state_d = S_RD;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_TRL:  if (xfer) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_trace_buffer_reader.sv
// Scoreboard bench for trace_buffer_reader: stimulus pushes expected bytes and end-of-dump
// checks into queues; a negedge monitor pops and compares them.
module tb_trace_buffer_reader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dump_req = 1'b0, dump8 = 1'b0;
    logic        byte_ready = 1'b0;
    logic        flush = 1'b0;
    logic        tb_empty, tb_empty8;
    logic [31:0] fifo_dout = '0;
    logic [7:0]  fifo_dout8 = '0;
    logic        fifo_rd, fifo_rd8, byte_valid, byte_valid8, busy, busy8;
    logic [7:0]  byte_out, byte_out8;
    logic [9:0]  words_sent, words_sent8;

    logic [31:0] mem [1024];
    logic [7:0]  mem8 [16];
    int wptr = 0, rptr = 0, wptr8 = 0, rptr8 = 0;

    typedef struct { string nm; longint act; longint exp; } chk_t;
    chk_t       chk_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] exp8_q [$];
    int errs = 0, checks = 0, rd_cnt = 0, rd8_cnt = 0;

    always #5 clk = ~clk;

    assign tb_empty  = (wptr == rptr);
    assign tb_empty8 = (wptr8 == rptr8);

    trace_buffer_reader #(.Fpay(32), .TB_Depth(512), .CNTw(10)) dut (
        .clk(clk), .reset(reset), .dump_req(dump_req), .tb_empty(tb_empty),
        .fifo_dout(fifo_dout), .fifo_rd(fifo_rd), .byte_out(byte_out),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .busy(busy),
        .words_sent(words_sent));

    trace_buffer_reader #(.Fpay(8), .TB_Depth(512), .CNTw(10)) dut8 (
        .clk(clk), .reset(reset), .dump_req(dump8), .tb_empty(tb_empty8),
        .fifo_dout(fifo_dout8), .fifo_rd(fifo_rd8), .byte_out(byte_out8),
        .byte_valid(byte_valid8), .byte_ready(byte_ready), .busy(busy8),
        .words_sent(words_sent8));

    // Trace FIFO models: data appears the cycle after the pop strobe.
    initial forever begin
        @(posedge clk);
        if (flush) rptr <= wptr;
        else if (fifo_rd && !tb_empty) begin
            fifo_dout <= mem[rptr];
            rptr      <= rptr + 1;
        end
        if (fifo_rd8 && !tb_empty8) begin
            fifo_dout8 <= mem8[rptr8];
            rptr8      <= rptr8 + 1;
        end
    end

    // Monitor: byte transfers, stall stability, pop legality and posted checks.
    initial begin
        chk_t       c;
        logic [7:0] e, held;
        logic       stall;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                checks++;
                if (c.act != c.exp) begin
                    errs++;
                    $display("FAIL %s: got %0h expected %0h", c.nm, c.act, c.exp);
                end
            end
            if (reset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    checks++;
                    if (!byte_valid || byte_out !== held) begin
                        errs++;
                        $display("FAIL stall_hold: got valid=%0b byte=%02h expected valid=1 byte=%02h",
                                 byte_valid, byte_out, held);
                    end
                end
                stall = byte_valid && !byte_ready;
                held  = byte_out;
                if (byte_valid && byte_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errs++;
                        $display("FAIL byte32: got %02h expected no byte", byte_out);
                    end else begin
                        e = exp_q.pop_front();
                        if (byte_out !== e) begin
                            errs++;
                            $display("FAIL byte32: got %02h expected %02h", byte_out, e);
                        end
                    end
                end
                if (byte_valid8 && byte_ready) begin
                    checks++;
                    if (exp8_q.size() == 0) begin
                        errs++;
                        $display("FAIL byte8: got %02h expected no byte", byte_out8);
                    end else begin
                        e = exp8_q.pop_front();
                        if (byte_out8 !== e) begin
                            errs++;
                            $display("FAIL byte8: got %02h expected %02h", byte_out8, e);
                        end
                    end
                end
                if (fifo_rd) begin
                    rd_cnt++;
                    if (tb_empty) begin
                        errs++;
                        $display("FAIL rd_on_empty: got fifo_rd=1 expected 0");
                    end
                end
                if (fifo_rd8) rd8_cnt++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic post(input string nm, input longint act, input longint exp);
        chk_t c;
        c.nm  = nm;
        c.act = act;
        c.exp = exp;
        chk_q.push_back(c);
    endtask

    task automatic push_word(input logic [31:0] w, input bit expect_it);
        mem[wptr] = w;
        wptr++;
        if (expect_it) begin
            exp_q.push_back(w[31:24]);
            exp_q.push_back(w[23:16]);
            exp_q.push_back(w[15:8]);
            exp_q.push_back(w[7:0]);
        end
    endtask

    task automatic start(input bit d32, input bit d8);
        dump_req = d32;
        dump8    = d8;
        tick;
        dump_req = 1'b0;
        dump8    = 1'b0;
        if (d32) post("busy_after_req", busy, 1);
        if (d8)  post("busy8_after_req", busy8, 1);
    endtask

    // mode 0: ready always high; mode 1: ready high one cycle in three.
    task automatic run_frame(input int mode, input int budget, input int repulse_at,
                             input int extra_at);
        bit done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            byte_ready = (mode == 0) ? 1'b1 : (i % 3 == 0);
            dump_req   = (i == repulse_at);
            if (i == extra_at)
                for (int k = 0; k < 8; k++) push_word(32'hEE00_0000 + 32'(k), 1'b0);
            tick;
            if (exp_q.size() == 0 && exp8_q.size() == 0 && !busy && !busy8) begin
                done = 1'b1;
                break;
            end
        end
        dump_req   = 1'b0;
        byte_ready = 1'b1;
        post("frame_done", done, 1);
    endtask

    initial begin
        int r0;
        bit hit;
        repeat (3) tick;
        post("rst_byte_valid", byte_valid, 0);
        post("rst_busy", busy, 0);
        post("rst_fifo_rd", fifo_rd, 0);
        post("rst_byte_out", byte_out, 0);
        post("rst_words_sent", words_sent, 0);
        reset = 1'b0;
        tick;

        // T1: empty FIFO gives header and trailer only
        r0 = rd_cnt;
        exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
        start(1, 0);
        run_frame(0, 50, -1, -1);
        post("t1_pops", rd_cnt - r0, 0);
        post("t1_words_sent", words_sent, 0);

        // T2: two words, sink always ready
        r0 = rd_cnt;
        exp_q.push_back(8'hA5);
        push_word(32'h1122_3344, 1'b1);
        push_word(32'hDEAD_BEEF, 1'b1);
        exp_q.push_back(8'h5A);
        start(1, 0);
        run_frame(0, 100, -1, -1);
        post("t2_pops", rd_cnt - r0, 2);
        post("t2_words_sent", words_sent, 2);

        // T3: same data, sink ready one cycle in three
        r0 = rd_cnt;
        exp_q.push_back(8'hA5);
        push_word(32'h1122_3344, 1'b1);
        push_word(32'hDEAD_BEEF, 1'b1);
        exp_q.push_back(8'h5A);
        start(1, 0);
        run_frame(1, 200, -1, -1);
        post("t3_pops", rd_cnt - r0, 2);
        post("t3_words_sent", words_sent, 2);

        // T4: full FIFO with writes landing mid-dump; cap at 512 words
        r0 = rd_cnt;
        exp_q.push_back(8'hA5);
        for (int i = 0; i < 512; i++) push_word(32'h1000_0000 + 32'(i) * 32'h0001_0003, 1'b1);
        exp_q.push_back(8'h5A);
        start(1, 0);
        run_frame(0, 5000, -1, 200);
        post("t4_pops", rd_cnt - r0, 512);
        post("t4_words_sent", words_sent, 512);
        repeat (5) tick;
        post("t4_ws_hold", words_sent, 512);
        post("t4_left_in_fifo", wptr - rptr, 8);
        flush = 1'b1; tick; flush = 1'b0;

        // T5: re-pulsed dump_req mid-frame is dropped
        exp_q.push_back(8'hA5);
        push_word(32'hCAFE_F00D, 1'b1);
        push_word(32'h0102_0304, 1'b1);
        exp_q.push_back(8'h5A);
        start(1, 0);
        run_frame(0, 100, 5, -1);
        repeat (10) tick;
        post("t5_no_refire", busy, 0);
        post("t5_words_sent", words_sent, 2);

        // T5b: reset mid-SEND aborts with no trailer
        r0 = rd_cnt;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h55); exp_q.push_back(8'h66);
        push_word(32'h5566_7788, 1'b0);
        push_word(32'h99AA_BBCC, 1'b0);
        byte_ready = 1'b1;
        start(1, 0);
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick;
            if (exp_q.size() == 0) begin hit = 1'b1; break; end
        end
        post("t5b_reached_send", hit, 1);
        byte_ready = 1'b0;
        reset      = 1'b1;
        tick;
        post("t5b_byte_valid", byte_valid, 0);
        post("t5b_busy", busy, 0);
        post("t5b_fifo_rd", fifo_rd, 0);
        post("t5b_words_sent", words_sent, 0);
        reset      = 1'b0;
        byte_ready = 1'b1;
        repeat (5) tick;
        post("t5b_pops", rd_cnt - r0, 1);
        flush = 1'b1; tick; flush = 1'b0;

        // T6: byte-wide build
        r0 = rd8_cnt;
        mem8[wptr8] = 8'h7E;
        wptr8++;
        exp8_q.push_back(8'hA5); exp8_q.push_back(8'h7E); exp8_q.push_back(8'h5A);
        start(0, 1);
        run_frame(0, 50, -1, -1);
        post("t6_pops", rd8_cnt - r0, 1);
        post("t6_words_sent", words_sent8, 1);

        repeat (3) tick;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
